otter_id_ex_stage: RTL and testbench

OTTER_ID_EX_STAGE -- requirements
Module: otter_id_ex_stage

---
 rtl/otter_id_ex_stage.sv | 117 +++++++++++
 tb/tb_otter_id_ex_stage.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/otter_id_ex_stage.sv
// otter_id_ex_stage: ID/EX pipeline register with flush, hold and load-use bubble insertion
module otter_id_ex_stage #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid_i,
    input  logic [XLEN-1:0]  id_pc_i,
    input  logic [XLEN-1:0]  id_ir_i,
    input  logic [XLEN-1:0]  id_rs1_data_i,
    input  logic [XLEN-1:0]  id_rs2_data_i,
    input  logic             id_alu_srca_i,
    input  logic [1:0]       id_alu_srcb_i,
    input  logic [3:0]       id_alu_fun_i,
    input  logic [1:0]       id_rf_wr_sel_i,
    input  logic             id_reg_write_i,
    input  logic             id_mem_read_i,
    input  logic             id_mem_write_i,
    input  logic             ex_flush_i,
    input  logic             ex_ready_i,
    output logic             id_stall_o,
    output logic             ex_valid_o,
    output logic [XLEN-1:0]  ex_pc_o,
    output logic [XLEN-1:0]  ex_ir_o,
    output logic [XLEN-1:0]  ex_rs1_data_o,
    output logic [XLEN-1:0]  ex_rs2_data_o,
    output logic             ex_alu_srca_o,
    output logic [1:0]       ex_alu_srcb_o,
    output logic [3:0]       ex_alu_fun_o,
    output logic [1:0]       ex_rf_wr_sel_o,
    output logic             ex_reg_write_o,
    output logic             ex_mem_read_o,
    output logic             ex_mem_write_o,
    output logic [4:0]       ex_rd_o,
    output logic [CNT_W-1:0] bubble_cnt_o
);
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [XLEN-1:0] NOP  = XLEN'(32'h00000013);

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] ir;
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
        logic            srca;
        logic [1:0]      srcb;
        logic [3:0]      fun;
        logic [1:0]      wsel;
        logic            rw;
        logic            mr;
        logic            mw;
    } ex_t;

    ex_t              ex_q, ex_d, bubble, id_ex;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       rd;
    logic [6:0]       opc;
    logic             use_rs1, use_rs2, hazard, do_bubble;

    assign rd  = ex_q.ir[11:7];
    assign opc = id_ir_i[6:0];

    // Detect a load in EX whose destination is read by the instruction in ID
    always_comb begin
        use_rs1   = !(opc == OP_LUI || opc == OP_AUIPC || opc == OP_JAL);
        use_rs2   = opc == OP_OP || opc == OP_STORE || opc == OP_BRANCH;
        hazard    = ex_q.valid && ex_q.mr && id_valid_i && rd != 5'd0 &&
                    ((use_rs1 && rd == id_ir_i[19:15]) || (use_rs2 && rd == id_ir_i[24:20]));
        id_stall_o = !ex_flush_i && (!ex_ready_i || hazard);
        do_bubble  = !ex_flush_i && ex_ready_i && hazard;
    end

    // Choose next register contents: flush, hold, bubble, then advance
    always_comb begin
        bubble    = '0;
        bubble.ir = NOP;
        id_ex     = '{valid: 1'b1, pc: id_pc_i, ir: id_ir_i, rs1: id_rs1_data_i, rs2: id_rs2_data_i,
                      srca: id_alu_srca_i, srcb: id_alu_srcb_i, fun: id_alu_fun_i, wsel: id_rf_wr_sel_i,
                      rw: id_reg_write_i, mr: id_mem_read_i, mw: id_mem_write_i};
        ex_d      = ex_flush_i ? bubble : !ex_ready_i ? ex_q : hazard ? bubble : id_valid_i ? id_ex : bubble;
        cnt_d     = (do_bubble && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
    end

    // Pipeline register and saturating bubble counter; reset leaves a bubble behind
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q    <= '0;
            ex_q.ir <= NOP;
            cnt_q   <= '0;
        end else begin
            ex_q    <= ex_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ex_valid_o     = ex_q.valid;
    assign ex_pc_o        = ex_q.pc;
    assign ex_ir_o        = ex_q.ir;
    assign ex_rs1_data_o  = ex_q.rs1;
    assign ex_rs2_data_o  = ex_q.rs2;
    assign ex_alu_srca_o  = ex_q.srca;
    assign ex_alu_srcb_o  = ex_q.srcb;
    assign ex_alu_fun_o   = ex_q.fun;
    assign ex_rf_wr_sel_o = ex_q.wsel;
    assign ex_reg_write_o = ex_q.rw;
    assign ex_mem_read_o  = ex_q.mr;
    assign ex_mem_write_o = ex_q.mw;
    assign ex_rd_o        = rd;
    assign bubble_cnt_o   = cnt_q;
endmodule

// File: tb/tb_otter_id_ex_stage.sv
// tb_otter_id_ex_stage: vector table and scoreboard bench for the ID/EX stage
module tb_otter_id_ex_stage;
    localparam logic [31:0] NOP  = 32'h00000013;
    localparam logic [31:0] ADDI = 32'h00A00093;
    localparam logic [31:0] LW5  = 32'h0000A283;
    localparam logic [31:0] ADD  = 32'h00728333;
    localparam logic [31:0] LUI  = 32'h123452B7;
    localparam logic [31:0] LW0  = 32'h0000A003;
    localparam logic [31:0] ADD0 = 32'h00700333;

    logic clk = 1'b0, rst_n = 1'b0;
    logic id_valid = 1'b0, id_mem_read = 1'b0, ex_flush = 1'b0, ex_ready = 1'b1;
    logic [31:0] id_pc = '0, id_ir = '0, id_rs1 = '0, id_rs2 = '0;
    logic id_srca = 1'b1, id_reg_write = 1'b1, id_mem_write = 1'b1;
    logic [1:0] id_srcb = 2'd2, id_wsel = 2'd3;
    logic [3:0] id_fun = 4'h5;

    logic id_stall, ex_valid, ex_srca, ex_rw, ex_mr, ex_mw;
    logic [31:0] ex_pc, ex_ir, ex_rs1, ex_rs2;
    logic [1:0] ex_srcb, ex_wsel;
    logic [3:0] ex_fun;
    logic [4:0] ex_rd;
    logic [15:0] cnt;

    logic s_stall, s_valid, s_srca, s_rw, s_mr, s_mw;
    logic [31:0] s_pc, s_ir, s_rs1, s_rs2;
    logic [1:0] s_srcb, s_wsel, s_cnt;
    logic [3:0] s_fun;
    logic [4:0] s_rd;

    always #5 clk = ~clk;

    otter_id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .id_valid_i(id_valid), .id_pc_i(id_pc), .id_ir_i(id_ir),
        .id_rs1_data_i(id_rs1), .id_rs2_data_i(id_rs2), .id_alu_srca_i(id_srca), .id_alu_srcb_i(id_srcb),
        .id_alu_fun_i(id_fun), .id_rf_wr_sel_i(id_wsel), .id_reg_write_i(id_reg_write),
        .id_mem_read_i(id_mem_read), .id_mem_write_i(id_mem_write), .ex_flush_i(ex_flush),
        .ex_ready_i(ex_ready), .id_stall_o(id_stall), .ex_valid_o(ex_valid), .ex_pc_o(ex_pc),
        .ex_ir_o(ex_ir), .ex_rs1_data_o(ex_rs1), .ex_rs2_data_o(ex_rs2), .ex_alu_srca_o(ex_srca),
        .ex_alu_srcb_o(ex_srcb), .ex_alu_fun_o(ex_fun), .ex_rf_wr_sel_o(ex_wsel),
        .ex_reg_write_o(ex_rw), .ex_mem_read_o(ex_mr), .ex_mem_write_o(ex_mw), .ex_rd_o(ex_rd),
        .bubble_cnt_o(cnt)
    );

    otter_id_ex_stage #(.XLEN(32), .CNT_W(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .id_valid_i(id_valid), .id_pc_i(id_pc), .id_ir_i(id_ir),
        .id_rs1_data_i(id_rs1), .id_rs2_data_i(id_rs2), .id_alu_srca_i(id_srca), .id_alu_srcb_i(id_srcb),
        .id_alu_fun_i(id_fun), .id_rf_wr_sel_i(id_wsel), .id_reg_write_i(id_reg_write),
        .id_mem_read_i(id_mem_read), .id_mem_write_i(id_mem_write), .ex_flush_i(ex_flush),
        .ex_ready_i(ex_ready), .id_stall_o(s_stall), .ex_valid_o(s_valid), .ex_pc_o(s_pc),
        .ex_ir_o(s_ir), .ex_rs1_data_o(s_rs1), .ex_rs2_data_o(s_rs2), .ex_alu_srca_o(s_srca),
        .ex_alu_srcb_o(s_srcb), .ex_alu_fun_o(s_fun), .ex_rf_wr_sel_o(s_wsel),
        .ex_reg_write_o(s_rw), .ex_mem_read_o(s_mr), .ex_mem_write_o(s_mw), .ex_rd_o(s_rd),
        .bubble_cnt_o(s_cnt)
    );

    typedef struct {
        logic        fl, rdy, idv, mr;
        logic [31:0] pc, ir;
        logic        e_stall, e_valid, e_mr;
        logic [31:0] e_pc, e_ir;
        logic [4:0]  e_rd;
        int          e_cnt;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int checks = 0, failures = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t v(logic fl, logic rdy, logic idv, logic mr, logic [31:0] pc, logic [31:0] ir,
                               logic st, logic ev, logic emr, logic [31:0] epc, logic [31:0] eir,
                               logic [4:0] erd, int ecnt);
        vec_t r;
        r.fl = fl; r.rdy = rdy; r.idv = idv; r.mr = mr; r.pc = pc; r.ir = ir;
        r.e_stall = st; r.e_valid = ev; r.e_mr = emr; r.e_pc = epc; r.e_ir = eir; r.e_rd = erd; r.e_cnt = ecnt;
        return r;
    endfunction

    task automatic drive(input vec_t t);
        ex_flush = t.fl; ex_ready = t.rdy; id_valid = t.idv; id_mem_read = t.mr;
        id_pc = t.pc; id_ir = t.ir; id_rs1 = t.pc + 32'd1; id_rs2 = t.pc + 32'd2;
        id_mem_write = ~t.mr;
    endtask

    task automatic compare(input vec_t e);
        logic [127:0] ctl;
        int sat;
        ctl = e.e_valid ? {e.e_pc + 32'd1, e.e_pc + 32'd2, 1'b1, 2'd2, 4'h5, 2'd3, 1'b1, ~e.e_mr} : '0;
        sat = e.e_cnt > 3 ? 3 : e.e_cnt;
        chk("ex_valid", ex_valid, e.e_valid);
        chk("ex_pc", ex_pc, e.e_pc);
        chk("ex_ir", ex_ir, e.e_ir);
        chk("ex_rd", ex_rd, e.e_rd);
        chk("ex_mem_read", ex_mr, e.e_mr);
        chk("ex_ctl", {ex_rs1, ex_rs2, ex_srca, ex_srcb, ex_fun, ex_wsel, ex_rw, ex_mw}, ctl);
        chk("bubble_cnt", cnt, 128'(e.e_cnt));
        chk("bubble_cnt_sat", s_cnt, 128'(sat));
    endtask

    task automatic run_vec(input vec_t t);
        @(negedge clk);
        drive(t);
        #1;
        chk("id_stall", id_stall, t.e_stall);
        chk("id_stall_sat", s_stall, t.e_stall);
        sb.push_back(t);
        @(posedge clk);
        #1;
        compare(sb.pop_front());
    endtask

    initial begin
        tbl.push_back(v(0,1,1,0,32'h100,ADDI, 0, 1,0,32'h100,ADDI,5'd1,0));
        tbl.push_back(v(0,1,1,1,32'h104,LW5,  0, 1,1,32'h104,LW5, 5'd5,0));
        tbl.push_back(v(0,1,1,0,32'h108,ADD,  1, 0,0,32'h0,  NOP, 5'd0,1));
        tbl.push_back(v(0,1,1,0,32'h108,ADD,  0, 1,0,32'h108,ADD, 5'd6,1));
        tbl.push_back(v(0,1,1,1,32'h10C,LW5,  0, 1,1,32'h10C,LW5, 5'd5,1));
        tbl.push_back(v(0,1,1,0,32'h110,LUI,  0, 1,0,32'h110,LUI, 5'd5,1));
        tbl.push_back(v(0,1,1,1,32'h114,LW0,  0, 1,1,32'h114,LW0, 5'd0,1));
        tbl.push_back(v(0,1,1,0,32'h118,ADD0, 0, 1,0,32'h118,ADD0,5'd6,1));
        tbl.push_back(v(0,1,1,1,32'h11C,LW5,  0, 1,1,32'h11C,LW5, 5'd5,1));
        tbl.push_back(v(1,0,1,0,32'h120,ADD,  0, 0,0,32'h0,  NOP, 5'd0,1));
        tbl.push_back(v(0,1,1,1,32'h124,LW5,  0, 1,1,32'h124,LW5, 5'd5,1));
        for (int i = 0; i < 3; i++)
            tbl.push_back(v(0,0,1,0,32'h128,ADD, 1, 1,1,32'h124,LW5,5'd5,1));
        tbl.push_back(v(0,1,1,0,32'h128,ADD,  1, 0,0,32'h0,  NOP, 5'd0,2));
        tbl.push_back(v(0,1,0,0,32'h12C,ADD,  0, 0,0,32'h0,  NOP, 5'd0,2));
        for (int k = 0; k < 5; k++) begin
            tbl.push_back(v(0,1,1,1,32'h200 + 32'(8*k),LW5, 0, 1,1,32'h200 + 32'(8*k),LW5,5'd5,2+k));
            tbl.push_back(v(0,1,1,0,32'h204 + 32'(8*k),ADD, 1, 0,0,32'h0,NOP,5'd0,3+k));
        end

        #12;
        chk("rst_valid", ex_valid, 1'b0);
        chk("rst_ir", ex_ir, NOP);
        chk("rst_cnt", cnt, 16'd0);
        chk("rst_stall", id_stall, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) run_vec(tbl[i]);

        run_vec(v(0,1,1,1,32'h300,LW5, 0, 1,1,32'h300,LW5,5'd5,7));
        @(negedge clk);
        drive(v(0,0,1,0,32'h304,ADD, 1, 0,0,0,NOP,0,0));
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", ex_valid, 1'b0);
        chk("midrst_ir", ex_ir, NOP);
        chk("midrst_cnt", cnt, 16'd0);
        chk("midrst_cnt_sat", s_cnt, 2'd0);
        chk("midrst_stall_hold", id_stall, 1'b1);
        ex_ready = 1'b1;
        #1;
        chk("midrst_stall_ready", id_stall, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(v(0,1,1,0,32'h308,ADDI, 0, 1,0,32'h308,ADDI,5'd1,0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
